// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 16x16 register file.
// Shares the single register-file write port between the ALU result path and
// the memory load path, and tracks which registers still await a write.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   alu_valid/rd/data      ALU write-back request
//   alu_ready              ALU request accepted this cycle (combinational)
//   mem_valid/rd/data      load write-back request
//   mem_ready              load request accepted this cycle (combinational)
//   issue_valid/issue_rd   decode issued an instruction writing issue_rd
//   Rd, R_Write, Gwe       registered register-file write port
//   busy_mask              bit i set while register i has a pending write
//   last_src               source of the most recent grant (0 = ALU, 1 = MEM)
//   wb_count               completed writes, wrapping
module rf_wb_arbiter #(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [3:0]       alu_rd,
  input  logic [15:0]      alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [3:0]       mem_rd,
  input  logic [15:0]      mem_data,
  output logic             mem_ready,
  input  logic             issue_valid,
  input  logic [3:0]       issue_rd,
  output logic [3:0]       Rd,
  output logic [15:0]      R_Write,
  output logic             Gwe,
  output logic [15:0]      busy_mask,
  output logic             last_src,
  output logic [CNT_W-1:0] wb_count
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 16;

  logic              grant;
  logic              grant_mem;
  logic [ADDR_W-1:0] grant_rd;
  logic [DATA_W-1:0] grant_data;
  logic [NREG-1:0]   busy_next;

  // MEM wins when alone, or on a tie when fixed priority or ALU went last.
  always_comb begin
    grant_mem  = 1'b0;
    alu_ready  = 1'b0;
    mem_ready  = 1'b0;
    grant      = alu_valid | mem_valid;
    if (mem_valid) begin
      if (!alu_valid || (PRIO_MODE == 1) || !last_src) begin
        grant_mem = 1'b1;
      end
    end
    mem_ready  = grant_mem;
    alu_ready  = alu_valid & ~grant_mem;
    grant_rd   = grant_mem ? mem_rd : alu_rd;
    grant_data = grant_mem ? mem_data : alu_data;
  end

  // Clear applied before set so a same-cycle re-issue keeps the bit pending.
  always_comb begin
    busy_next = busy_mask;
    if (grant) begin
      busy_next[grant_rd] = 1'b0;
    end
    if (issue_valid) begin
      busy_next[issue_rd] = 1'b1;
    end
  end

  // Output stage, arbitration history, scoreboard and event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      Rd        <= '0;
      R_Write   <= '0;
      Gwe       <= 1'b0;
      busy_mask <= '0;
      last_src  <= 1'b1;
      wb_count  <= '0;
    end else begin
      Gwe       <= grant;
      busy_mask <= busy_next;
      if (grant) begin
        Rd       <= grant_rd;
        R_Write  <= grant_data;
        last_src <= grant_mem;
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic against a rule-level reference model, for both arbitration modes.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic [3:0]  alu_rd, mem_rd, issue_rd;
  logic [15:0] alu_data, mem_data;

  logic        alu_ready0, mem_ready0, gwe0, last0;
  logic        alu_ready1, mem_ready1, gwe1, last1;
  logic [3:0]  rd0, rd1;
  logic [15:0] wdata0, wdata1, busy0, busy1, cnt0, cnt1;

  // Outputs of the instance under test for the current mode.
  logic        a_rdy, m_rdy, gwe, lsrc;
  logic [3:0]  rd_o;
  logic [15:0] wdata, busy, cnt;

  int mode;
  int errors;
  int checks;

  // Reference model state.
  logic        m_last;
  logic [15:0] m_busy, m_cnt, m_data;
  logic [3:0]  m_rd;
  logic        m_gwe;

  rf_wb_arbiter #(.PRIO_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready0),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready0),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .Rd(rd0), .R_Write(wdata0), .Gwe(gwe0), .busy_mask(busy0),
    .last_src(last0), .wb_count(cnt0)
  );

  rf_wb_arbiter #(.PRIO_MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready1),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready1),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .Rd(rd1), .R_Write(wdata1), .Gwe(gwe1), .busy_mask(busy1),
    .last_src(last1), .wb_count(cnt1)
  );

  always_comb begin
    if (mode == 1) begin
      a_rdy = alu_ready1; m_rdy = mem_ready1; gwe = gwe1; lsrc = last1;
      rd_o = rd1; wdata = wdata1; busy = busy1; cnt = cnt1;
    end else begin
      a_rdy = alu_ready0; m_rdy = mem_ready0; gwe = gwe0; lsrc = last0;
      rd_o = rd0; wdata = wdata0; busy = busy0; cnt = cnt0;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Grant chosen by the arbitration rules: 0 none, 1 ALU, 2 MEM.
  function automatic int pick();
    if (alu_valid && mem_valid) return (mode == 1 || m_last == 1'b0) ? 2 : 1;
    if (alu_valid) return 1;
    if (mem_valid) return 2;
    return 0;
  endfunction

  // Advance the reference model by one clock edge using the current inputs.
  task automatic model_edge();
    int g;
    g = pick();
    if (rst) begin
      m_rd = 4'h0; m_data = 16'h0; m_gwe = 1'b0;
      m_busy = 16'h0; m_last = 1'b1; m_cnt = 16'h0;
    end else begin
      m_gwe = (g != 0);
      if (g == 1) begin
        m_rd = alu_rd; m_data = alu_data; m_last = 1'b0;
        m_busy[alu_rd] = 1'b0; m_cnt = m_cnt + 16'd1;
      end else if (g == 2) begin
        m_rd = mem_rd; m_data = mem_data; m_last = 1'b1;
        m_busy[mem_rd] = 1'b0; m_cnt = m_cnt + 16'd1;
      end
      if (issue_valid) m_busy[issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 4'h0; alu_data = 16'h0;
    mem_valid = 1'b0; mem_rd = 4'h0; mem_data = 16'h0;
    issue_valid = 1'b0; issue_rd = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 0;
    do_reset();
    repeat (3) tick();
    checks++; if (gwe !== 1'b0) begin errors++; $display("FAIL reset_gwe got=%0h exp=0", gwe); end
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0000", busy); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", cnt); end
    checks++; if (rd_o !== 4'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd_o); end
    checks++; if (wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0000", wdata); end
    checks++; if (lsrc !== 1'b1) begin errors++; $display("FAIL reset_last got=%0h exp=1", lsrc); end
  endtask

  task automatic test_single();
    mode = 0;
    do_reset();
    issue_valid = 1'b1; issue_rd = 4'hF;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'hF; alu_data = 16'hAAAA;
    #1;
    checks++; if (busy !== 16'h8000) begin errors++; $display("FAIL single_busy_pre got=%h exp=8000", busy); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL single_alu_ready got=%0h exp=1", a_rdy); end
    tick();
    idle_inputs();
    checks++; if (rd_o !== 4'hF) begin errors++; $display("FAIL single_rd got=%h exp=f", rd_o); end
    checks++; if (wdata !== 16'hAAAA) begin errors++; $display("FAIL single_wdata got=%h exp=aaaa", wdata); end
    checks++; if (gwe !== 1'b1) begin errors++; $display("FAIL single_gwe got=%0h exp=1", gwe); end
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL single_busy_post got=%h exp=0000", busy); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got=%h exp=0001", cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rd [4];
    exp_rd[0] = 4'd1; exp_rd[1] = 4'd2; exp_rd[2] = 4'd1; exp_rd[3] = 4'd2;
    mode = 0;
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_rdy !== (exp_rd[i] == 4'd1) || m_rdy !== (exp_rd[i] == 4'd2)) begin
        errors++; $display("FAIL rr_ready[%0d] got alu=%0h mem=%0h exp_rd=%0d", i, a_rdy, m_rdy, exp_rd[i]);
      end
      tick();
      checks++; if (gwe !== 1'b1) begin errors++; $display("FAIL rr_gwe[%0d] got=%0h exp=1", i, gwe); end
      checks++; if (rd_o !== exp_rd[i]) begin errors++; $display("FAIL rr_rd[%0d] got=%0d exp=%0d", i, rd_o, exp_rd[i]); end
    end
    idle_inputs();
    tick();
    checks++; if (gwe !== 1'b0) begin errors++; $display("FAIL rr_idle_gwe got=%0h exp=0", gwe); end
  endtask

  task automatic test_fixed_prio();
    mode = 1;
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h0003;
    mem_valid = 1'b1; mem_rd = 4'd3; mem_data = 16'h0030;
    #1;
    checks++; if (m_rdy !== 1'b1 || a_rdy !== 1'b0) begin errors++; $display("FAIL prio_first got alu=%0h mem=%0h exp alu=0 mem=1", a_rdy, m_rdy); end
    tick();
    mem_valid = 1'b0;
    checks++; if (wdata !== 16'h0030 || gwe !== 1'b1) begin errors++; $display("FAIL prio_mem_write got=%h gwe=%0h exp=0030 gwe=1", wdata, gwe); end
    #1;
    checks++; if (a_rdy !== 1'b1 || m_rdy !== 1'b0) begin errors++; $display("FAIL prio_second got alu=%0h mem=%0h exp alu=1 mem=0", a_rdy, m_rdy); end
    tick();
    idle_inputs();
    checks++; if (rd_o !== 4'd3 || wdata !== 16'h0003 || gwe !== 1'b1) begin errors++; $display("FAIL prio_alu_write got rd=%0d data=%h gwe=%0h exp rd=3 data=0003 gwe=1", rd_o, wdata, gwe); end
    tick();
    checks++; if (gwe !== 1'b0 || wdata !== 16'h0003) begin errors++; $display("FAIL prio_hold got data=%h gwe=%0h exp data=0003 gwe=0", wdata, gwe); end
  endtask

  task automatic test_set_clear();
    mode = 0;
    do_reset();
    issue_valid = 1'b1; issue_rd = 4'd5;
    tick();
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h5555;
    #1;
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL sc_ready got=%0h exp=1", a_rdy); end
    tick();
    checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL sc_set_wins got=%h exp=0020", busy); end
    alu_valid = 1'b0; issue_rd = 4'd7;
    tick();
    issue_rd = 4'd6;
    alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h7777;
    tick();
    idle_inputs();
    checks++; if (busy !== 16'h0060) begin errors++; $display("FAIL sc_diff_bits got=%h exp=0060", busy); end
  endtask

  task automatic test_reset_drop();
    mode = 0;
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'h9999;
    issue_valid = 1'b1; issue_rd = 4'd9;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++; if (gwe !== 1'b0) begin errors++; $display("FAIL drop_gwe got=%0h exp=0", gwe); end
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL drop_busy got=%h exp=0000", busy); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL drop_cnt got=%h exp=0000", cnt); end
  endtask

  task automatic test_wrap();
    mode = 0;
    do_reset();
    alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 16'h1234;
    repeat (65535) tick();
    checks++; if (cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%h exp=ffff", cnt); end
    tick();
    idle_inputs();
    checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", cnt); end
  endtask

  task automatic test_random(input int md);
    logic apend, mpend;
    int g;
    mode = md;
    do_reset();
    apend = 1'b0; mpend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!apend && $urandom_range(0, 2) != 0) begin
        apend = 1'b1; alu_rd = 4'($urandom); alu_data = 16'($urandom);
      end
      if (!mpend && $urandom_range(0, 2) != 0) begin
        mpend = 1'b1; mem_rd = 4'($urandom); mem_data = 16'($urandom);
      end
      alu_valid = apend; mem_valid = mpend;
      issue_valid = 1'($urandom); issue_rd = 4'($urandom);
      #1;
      g = pick();
      checks++;
      if (a_rdy !== (g == 1) || m_rdy !== (g == 2)) begin
        errors++; $display("FAIL rnd%0d_ready[%0d] got alu=%0h mem=%0h exp grant=%0d", md, i, a_rdy, m_rdy, g);
      end
      tick();
      if (g == 1) apend = 1'b0;
      if (g == 2) mpend = 1'b0;
      checks++;
      if (gwe !== m_gwe || rd_o !== m_rd || wdata !== m_data) begin
        errors++; $display("FAIL rnd%0d_port[%0d] got gwe=%0h rd=%h data=%h exp gwe=%0h rd=%h data=%h", md, i, gwe, rd_o, wdata, m_gwe, m_rd, m_data);
      end
      checks++;
      if (busy !== m_busy || cnt !== m_cnt || lsrc !== m_last) begin
        errors++; $display("FAIL rnd%0d_state[%0d] got busy=%h cnt=%h last=%0h exp busy=%h cnt=%h last=%0h", md, i, busy, cnt, lsrc, m_busy, m_cnt, m_last);
      end
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mode = 0;
    rst = 1'b1;
    idle_inputs();
    m_last = 1'b1; m_busy = 16'h0; m_cnt = 16'h0;
    m_data = 16'h0; m_rd = 4'h0; m_gwe = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_prio();
    test_set_clear();
    test_reset_drop();
    test_random(0);
    test_random(1);
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter and pending-write scoreboard for the 16x16 register file. It shares the register file's single write port between two requesters: the ALU result path and the memory load path. It drives the register file write port (Rd, R_Write, Gwe) from one registered output stage. It also keeps a 16-bit busy mask of registers with an issued but not-yet-written result, which decode uses for stall decisions.

Parameters:
PRIO_MODE, 0, 0 = round-robin between ALU and MEM; 1 = fixed priority, MEM always wins ties
CNT_W, 16, width of the write-back event counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU write-back request
alu_rd  in  4  ALU destination register
alu_data  in  16  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
mem_valid  in  1  load write-back request
mem_rd  in  4  load destination register
mem_data  in  16  load data
mem_ready  out  1  load request accepted this cycle (combinational)
issue_valid  in  1  decode issued an instruction with a register destination
issue_rd  in  4  destination register of the issued instruction
Rd  out  4  register file write address (registered)
R_Write  out  16  register file write data (registered)
Gwe  out  1  register file global write enable (registered, one-cycle pulse per write)
busy_mask  out  16  bit i = 1 means register i has a pending write
last_src  out  1  source of the most recent grant: 0 = ALU, 1 = MEM
wb_count  out  CNT_W  number of completed writes, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): Rd=0, R_Write=0, Gwe=0, busy_mask=0, last_src=1 (so the ALU wins the first tie), wb_count=0. A transfer accepted in the same cycle as reset is dropped: Gwe=0 on the following cycle and busy_mask stays 0.
- Handshake: a transfer occurs when x_valid && x_ready. At most one of alu_ready and mem_ready is 1 in any cycle. A requester holds valid, rd and data stable until it sees ready. Ready is never asserted without valid.
- Arbitration, with only one valid: that requester is granted.
- Arbitration, with both valid:
  - PRIO_MODE=0: grant the source opposite to last_src.
  - PRIO_MODE=1: grant MEM.
- On a grant, last_src updates to the granted source.
- Neither valid: no grant, last_src holds.
- Latency: a grant in cycle N gives Rd/R_Write = granted rd/data and Gwe=1 in cycle N+1. With no grant in cycle N, Gwe=0 in cycle N+1; Rd and R_Write hold their previous values.
- Throughput: one write per cycle. The write port is never idle while any request is pending.
- Same-destination conflict: when both requesters target the same rd in one cycle, the loser writes in a later cycle, so its value is the final content. No merging or dropping of requests.
- Scoreboard:
  - issue_valid sets busy_mask[issue_rd] at the next edge.
  - A granted transfer clears busy_mask[rd] at the next edge.
  - Set and clear of the same bit in one cycle: set wins, because a newer write is now pending.
  - Set and clear of different bits both take effect.
  - A grant to a register whose bit is already 0 is legal and leaves the bit at 0.
- wb_count increments by 1 on every grant and wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then idle 3 cycles -> Gwe=0, busy_mask=16'h0000, wb_count=0, Rd=0, R_Write=0.
- issue_valid with issue_rd=4'hF; next cycle alu_valid with rd=4'hF and data=16'hAAAA -> busy_mask=16'h8000 before the grant. In the grant cycle alu_ready=1. Next cycle Rd=4'hF, R_Write=16'hAAAA, Gwe=1, busy_mask=16'h0000, wb_count=1.
- PRIO_MODE=0, both valid for 4 cycles (ALU rd=1 data=16'h1111; MEM rd=2 data=16'h2222, each re-presented after acceptance) -> grant order ALU, MEM, ALU, MEM; Gwe=1 on 4 consecutive cycles; Rd sequence 1, 2, 1, 2.
- PRIO_MODE=1, both valid with rd=3 (ALU 16'h0003, MEM 16'h0030) -> MEM written first, ALU one cycle later; last Rd=3 has R_Write=16'h0003; mem_ready and alu_ready never both 1.
- Same cycle: issue_valid rd=5 plus ALU grant rd=5 with busy_mask[5]=1 -> busy_mask[5] remains 1. Same cycle: issue rd=6 plus grant rd=7 -> bit 6 set, bit 7 cleared.
- ALU grant of rd=9 in the same cycle as rst=1 -> next cycle Gwe=0, busy_mask=0, wb_count=0. Separately, force wb_count to 16'hFFFF and perform one write -> wb_count=0.
